// File: rtl/op_unit.sv
// Datapath for the microprogrammed shift-add sequence: registers A, B, C, R plus ovf/done/err flags.
// Define OP_UNIT_CONFLICT_EN to build the sticky same-register strobe conflict detector on err.
module op_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             t1,
  input  logic             t2,
  input  logic             t4,
  input  logic             t5,
  input  logic             t6,
  input  logic             t7,
  input  logic             t8,
  input  logic             t9,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  output logic             x,
  output logic             y,
  output logic [WIDTH-1:0] r,
  output logic             done,
  output logic             ovf,
  output logic             err
);

  localparam int                CNT_W  = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_INIT = CNT_W'(WIDTH);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CNT_W-1:0] c_q, c_d;
  logic             ovf_q, ovf_d;
  logic             done_q;
  logic [WIDTH:0]   sum;

  // NOTE: every signal assigned here gets its hold value first, so no latch can be inferred.
  always_comb begin
    sum   = {1'b0, a_q} + {1'b0, b_q};
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    r_d   = r_q;
    ovf_d = ovf_q;

    if (t9)      a_d = '0;
    else if (t4) a_d = din_a;
    else if (t1) a_d = sum[WIDTH-1:0];

    if (t9)                ovf_d = 1'b0;
    else if (t1 && sum[WIDTH]) ovf_d = 1'b1;

    if (t5)      b_d = din_b;
    else if (t2) b_d = b_q >> 1;

    // C saturates at zero so the controller can keep issuing t6 without wrap.
    if (t7)                  c_d = C_INIT;
    else if (t6 && c_q != '0) c_d = c_q - CNT_W'(1);

    if (t8) r_d = a_q;
  end

  // NOTE: non-blocking assignments make every register update from its pre-edge value.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      r_q    <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      r_q    <= r_d;
      ovf_q  <= ovf_d;
      done_q <= t8;
    end
  end

`ifdef OP_UNIT_CONFLICT_EN
  logic err_q;
  logic conflict;

  assign conflict = (t1 & t4) | (t1 & t9) | (t4 & t9) | (t2 & t5) | (t6 & t7);

  always_ff @(posedge clk or posedge res) begin
    if (res) err_q <= 1'b0;
    else     err_q <= err_q | conflict;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Flags decode from registers only, keeping the controller loop free of combinational paths.
  assign x    = b_q[0];
  assign y    = (c_q == '0);
  assign r    = r_q;
  assign done = done_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_op_unit.sv
// Scoreboard bench for op_unit: directed sequences plus random strobes against a behavioural model.
module tb_op_unit;

  localparam int WIDTH = 8;
  localparam int MOD   = 1 << WIDTH;
  localparam int T1 = 1 << 1, T2 = 1 << 2, T4 = 1 << 4, T5 = 1 << 5;
  localparam int T6 = 1 << 6, T7 = 1 << 7, T8 = 1 << 8, T9 = 1 << 9;

  logic clk, res;
  logic t1, t2, t4, t5, t6, t7, t8, t9;
  logic [WIDTH-1:0] din_a, din_b;
  logic x, y, done, ovf, err;
  logic [WIDTH-1:0] r;

  op_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .res(res),
    .t1(t1), .t2(t2), .t4(t4), .t5(t5), .t6(t6), .t7(t7), .t8(t8), .t9(t9),
    .din_a(din_a), .din_b(din_b),
    .x(x), .y(y), .r(r), .done(done), .ovf(ovf), .err(err)
  );

  typedef struct {
    int cyc;
    bit x, y, done, ovf, err;
    int r;
  } exp_t;

  exp_t exp_q[$];
  int   cycle_cnt = 0;
  int   n_checks  = 0;
  int   n_errors  = 0;

  // Reference model state
  int m_a, m_b, m_c, m_r;
  bit m_ovf, m_done, m_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_c = 0; m_r = 0;
    m_ovf = 0; m_done = 0; m_err = 0;
  endtask

  // Applies strobes for the coming edge, advances the model, queues the expected post-edge outputs.
  task automatic drive(input int mask, input int da = 0, input int db = 0);
    int sum, na, nb, nc;
    bit s1, s2, s4, s5, s6, s7, s8, s9;
    s1 = mask[1]; s2 = mask[2]; s4 = mask[4]; s5 = mask[5];
    s6 = mask[6]; s7 = mask[7]; s8 = mask[8]; s9 = mask[9];
    {t1, t2, t4, t5, t6, t7, t8, t9} = {s1, s2, s4, s5, s6, s7, s8, s9};
    din_a = WIDTH'(da);
    din_b = WIDTH'(db);

    sum = m_a + m_b;
    na  = s9 ? 0 : s4 ? da % MOD : s1 ? sum % MOD : m_a;
    nb  = s5 ? db % MOD : s2 ? m_b / 2 : m_b;
    nc  = s7 ? WIDTH : (s6 && m_c > 0) ? m_c - 1 : m_c;
    if (s8) m_r = m_a;
    if (s9) m_ovf = 0;
    else if (s1 && sum >= MOD) m_ovf = 1;
    m_done = s8;
`ifdef OP_UNIT_CONFLICT_EN
    if ((int'(s1) + int'(s4) + int'(s9)) >= 2 || (s2 && s5) || (s6 && s7)) m_err = 1;
`endif
    m_a = na; m_b = nb; m_c = nc;

    exp_q.push_back('{cyc: cycle_cnt + 1, x: bit'(m_b % 2), y: (m_c == 0),
                      done: m_done, ovf: m_ovf, err: m_err, r: m_r});
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every output once per cycle, away from the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cycle_cnt) begin
        e = exp_q.pop_front();
        check("sb_x",    int'(x),    int'(e.x));
        check("sb_y",    int'(y),    int'(e.y));
        check("sb_r",    int'(r),    e.r);
        check("sb_done", int'(done), int'(e.done));
        check("sb_ovf",  int'(ovf),  int'(e.ovf));
        check("sb_err",  int'(err),  int'(e.err));
      end
    end
  end

  // Async reset in the middle of a cycle, then release; model follows.
  task automatic pulse_reset();
    @(negedge clk);
    #1;
    {t1, t2, t4, t5, t6, t7, t8, t9} = '0;
    res = 1'b1;
    #1;
    check("rst_x",    int'(x),    0);
    check("rst_y",    int'(y),    1);
    check("rst_r",    int'(r),    0);
    check("rst_done", int'(done), 0);
    check("rst_ovf",  int'(ovf),  0);
    check("rst_err",  int'(err),  0);
    model_reset();
    @(posedge clk);
    #1;
    res = 1'b0;
  endtask

  initial begin
    int mask;
    int strobes[8] = '{1, 2, 4, 5, 6, 7, 8, 9};
    res = 1'b1;
    {t1, t2, t4, t5, t6, t7, t8, t9} = '0;
    din_a = '0;
    din_b = '0;
    model_reset();
    #1;
    check("init_y", int'(y), 1);
    check("init_x", int'(x), 0);
    repeat (2) @(posedge clk);
    #1;
    res = 1'b0;

    // Mid-sequence reset with A=0x55, C=3, R=0x55
    drive(T4 | T7, 'h55);
    repeat (5) drive(T6);
    drive(T8);
    check("pre_rst_r", int'(r), 'h55);
    check("pre_rst_y", int'(y), 0);
    pulse_reset();
    drive(0);
    drive(T8);
    check("post_rst_r", int'(r), 0);
    check("post_rst_y", int'(y), 1);

    // Load, add, shift
    drive(T4 | T5, 'h0F, 'h03);
    check("load_x", int'(x), 1);
    drive(T1);
    drive(T8 | T2);
    check("add_r", int'(r), 'h12);
    check("shift1_x", int'(x), 1);
    drive(T2);
    check("shift2_x", int'(x), 0);

    // Carry and sticky ovf
    drive(T4 | T5, 'hF0, 'h20);
    drive(T1);
    check("carry_ovf", int'(ovf), 1);
    drive(T1 | T8);
    check("carry_r", int'(r), 'h10);
    check("sticky_ovf", int'(ovf), 1);
    drive(T9 | T8);
    check("t9_ovf", int'(ovf), 0);
    check("nocarry_r", int'(r), 'h30);

    // Counter load and saturation
    drive(T7);
    check("cnt_load_y", int'(y), 0);
    for (int i = 0; i < 7; i++) drive(T6);
    check("cnt_7_y", int'(y), 0);
    drive(T6);
    check("cnt_8_y", int'(y), 1);
    drive(T6);
    check("cnt_sat_y", int'(y), 1);

    // t8 with t9: R takes old A, done is a single pulse
    drive(T4, 'h12);
    drive(T8 | T9);
    check("t8t9_r", int'(r), 'h12);
    check("t8t9_done", int'(done), 1);
    drive(T8);
    check("t8t9_a", int'(r), 0);
    drive(0);
    check("done_low", int'(done), 0);

    // A-register conflict: t4 wins over t1
    drive(T4 | T1, 'hAB, 'h01);
    drive(T8);
    check("conf_r", int'(r), 'hAB);
`ifdef OP_UNIT_CONFLICT_EN
    check("conf_err", int'(err), 1);
`else
    check("conf_err", int'(err), 0);
`endif

    // Random strobes with sparse density
    for (int n = 0; n < 400; n++) begin
      mask = 0;
      foreach (strobes[k])
        if ($urandom_range(0, 3) == 0) mask |= 1 << strobes[k];
      drive(mask, int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)));
    end

    pulse_reset();
    drive(0);
    check("final_err", int'(err), 0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
